// File: rtl/max_pool_2d_4_channel_size_2.sv
// 2x2 / stride-2 max pooling over a raster-ordered 4-channel feature map.
// All four channels share one col/row tracker. Each channel uses a horizontal
// holding register and a half-width line buffer, so the block never stores a
// full frame. A finished window's maximum is registered and flagged with
// valid_out one clock after its bottom-right pixel.
module max_pool_2d_4_channel_size_2 #(
    parameter int unsigned IMG_Width  = 4,
    parameter int unsigned IMG_Height = 4,
    parameter int unsigned Datawidth  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In_0,
    input  logic [Datawidth-1:0] In_1,
    input  logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] In_3,
    output logic                 valid_out,
    output logic [Datawidth-1:0] Out_0,
    output logic [Datawidth-1:0] Out_1,
    output logic [Datawidth-1:0] Out_2,
    output logic [Datawidth-1:0] Out_3,
    output logic                 frame_done
);

    localparam int unsigned HalfW = IMG_Width / 2;
    localparam int unsigned HalfH = IMG_Height / 2;
    localparam int unsigned ColW  = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
    localparam int unsigned RowW  = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;
    localparam int unsigned IdxW  = (HalfW > 1) ? $clog2(HalfW) : 1;
    localparam bit          EvenW = (IMG_Width % 2) == 0;
    localparam bit          EvenH = (IMG_Height % 2) == 0;

    typedef logic signed [Datawidth-1:0] sample_t;

    sample_t         in_s   [4];
    sample_t         h_q    [4];
    sample_t         h_d    [4];
    sample_t         out_q  [4];
    sample_t         out_d  [4];
    sample_t         wr_data[4];
    sample_t         line_q [4][HalfW];

    logic [ColW-1:0] col_q, col_d, half_col;
    logic [RowW-1:0] row_q, row_d;
    logic [IdxW-1:0] idx;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            wr_en;
    logic            col_last, row_last, col_used, row_used;

    // Signed maximum; on a tie either operand is the same value.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    assign in_s[0] = sample_t'(In_0);
    assign in_s[1] = sample_t'(In_1);
    assign in_s[2] = sample_t'(In_2);
    assign in_s[3] = sample_t'(In_3);

    assign Out_0      = out_q[0];
    assign Out_1      = out_q[1];
    assign Out_2      = out_q[2];
    assign Out_3      = out_q[3];
    assign valid_out  = valid_q;
    assign frame_done = done_q;

    assign col_last = (col_q == ColW'(IMG_Width - 1));
    assign row_last = (row_q == RowW'(IMG_Height - 1));
    // A trailing odd column/row is consumed but never joins a window.
    assign col_used = EvenW || !col_last;
    assign row_used = EvenH || !row_last;
    assign half_col = col_q >> 1;
    assign idx      = half_col[IdxW-1:0];

    // Next-state: position tracking plus the per-quadrant window actions.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        h_d     = h_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_data[k] = '0;
        end

        if (valid_in && !rst) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (col_used && row_used) begin
                case ({row_q[0], col_q[0]})
                    2'b00: begin
                        for (int k = 0; k < 4; k++) h_d[k] = in_s[k];
                    end
                    2'b01: begin
                        wr_en = 1'b1;
                        for (int k = 0; k < 4; k++) wr_data[k] = smax(h_q[k], in_s[k]);
                    end
                    2'b10: begin
                        for (int k = 0; k < 4; k++) h_d[k] = smax(line_q[k][idx], in_s[k]);
                    end
                    default: begin
                        for (int k = 0; k < 4; k++) out_d[k] = smax(h_q[k], in_s[k]);
                        valid_d = 1'b1;
                        done_d  = (row_q == RowW'(2 * HalfH - 1)) &&
                                  (col_q == ColW'(2 * HalfW - 1));
                    end
                endcase
            end
        end
    end

    // State registers with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '{default: '0};
            out_q   <= '{default: '0};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Line buffer: always written on an even row before being read, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                line_q[k][idx] <= wr_data[k];
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2d_4_channel_size_2.sv
// Directed bench for the 2x2 max-pool block: a 4x4 instance and a 5x5 instance.
module tb_max_pool_2d_4_channel_size_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, valid_in5;
    logic [31:0] in0, in1, in2, in3, in5;
    logic [31:0] out0, out1, out2, out3;
    logic [31:0] o5_0, o5_1, o5_2, o5_3;
    logic        valid_out, frame_done, valid_out5, frame_done5;

    int          total = 0;
    int          bad = 0;
    logic [31:0] hold0;

    int exp4 [4] = '{5, 7, 13, 15};
    int exp5 [4] = '{6, 8, 16, 18};
    int neg  [16] = '{-1, -5, -7, 6, -9, -3, -8, -2, -7, -7, -7, -7, -7, -7, -7, -7};
    int negx [4] = '{-1, 6, -7, -7};

    always #5 clk = ~clk;

    max_pool_2d_4_channel_size_2 dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .In_0(in0), .In_1(in1), .In_2(in2), .In_3(in3),
        .valid_out(valid_out),
        .Out_0(out0), .Out_1(out1), .Out_2(out2), .Out_3(out3),
        .frame_done(frame_done)
    );

    max_pool_2d_4_channel_size_2 #(.IMG_Width(5), .IMG_Height(5), .Datawidth(32)) dut5 (
        .clk(clk), .rst(rst), .valid_in(valid_in5),
        .In_0(in5), .In_1(32'd0), .In_2(32'd0), .In_3(32'd0),
        .valid_out(valid_out5),
        .Out_0(o5_0), .Out_1(o5_1), .Out_2(o5_2), .Out_3(o5_3),
        .frame_done(frame_done5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One valid pixel on the 4x4 instance, then check the cycle after.
    task automatic step4(input logic [31:0] v0, input logic [31:0] v3, input bit exp_v,
                         input logic [31:0] e0, input logic [31:0] e3, input bit exp_fd);
        in0 = v0; in1 = v0 + 32'd100; in2 = v0 + 32'd200; in3 = v3;
        valid_in = 1'b1;
        @(posedge clk); #1;
        chk("valid4", valid_out, exp_v);
        chk("done4", frame_done, exp_fd);
        if (exp_v) begin
            chk("out0", out0, e0);
            chk("out3", out3, e3);
            hold0 = e0;
        end else begin
            chk("hold0", out0, hold0);
        end
    endtask

    // Ramp frame In_k = r*4+c+100k; npix < 16 stops partway; gaps adds idle cycles.
    task automatic frame4(input bit gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            int r, c, w;
            bit ev;
            r  = p / 4;
            c  = p % 4;
            w  = (r / 2) * 2 + c / 2;
            ev = (r % 2 == 1) && (c % 2 == 1);
            step4(32'(r * 4 + c), 32'(r * 4 + c + 300), ev,
                  32'(exp4[w]), 32'(exp4[w] + 300), ev && r == 3 && c == 3);
            if (gaps) begin
                valid_in = 1'b0;
                in0 = 32'hDEAD_BEEF; in3 = 32'h7FFF_FFFF;
                @(posedge clk); #1;
                chk("gap_valid", valid_out, 1'b0);
                chk("gap_hold", out0, hold0);
            end
        end
    endtask

    task automatic do_reset(input bit with_valid);
        rst = 1'b1;
        valid_in = with_valid;
        @(posedge clk); #1;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_out0", out0, 32'd0);
        chk("rst_out1", out1, 32'd0);
        chk("rst_out2", out2, 32'd0);
        chk("rst_out3", out3, 32'd0);
        rst = 1'b0;
        valid_in = 1'b0;
        hold0 = 32'd0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; valid_in5 = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; in5 = '0;
        hold0 = '0;
        @(posedge clk); #1;
        do_reset(1'b0);
        chk("rst_valid5", valid_out5, 1'b0);
        chk("rst_o5", o5_0, 32'd0);

        // Continuous frame, then the same frame with idle cycles between pixels.
        frame4(1'b0, 16);
        frame4(1'b1, 16);

        // Signed comparison frame.
        for (int p = 0; p < 16; p++) begin
            int r, c;
            bit ev;
            r  = p / 4;
            c  = p % 4;
            ev = (r % 2 == 1) && (c % 2 == 1);
            step4(32'(neg[p]), 32'(neg[p]), ev, 32'(negx[(r / 2) * 2 + c / 2]),
                  32'(negx[(r / 2) * 2 + c / 2]), ev && r == 3 && c == 3);
        end

        // Abort after 6 pixels; rst wins over a concurrent valid_in.
        frame4(1'b0, 6);
        do_reset(1'b1);
        frame4(1'b0, 16);
        frame4(1'b0, 16);
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", valid_out, 1'b0);

        // 5x5: the last column and the last row produce nothing.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                bit ev;
                ev = (r % 2 == 1) && (c % 2 == 1) && r < 4 && c < 4;
                in5 = 32'(r * 5 + c);
                valid_in5 = 1'b1;
                @(posedge clk); #1;
                chk("valid5", valid_out5, ev);
                chk("done5", frame_done5, ev && r == 3 && c == 3);
                if (ev) chk("out5", o5_0, 32'(exp5[(r / 2) * 2 + c / 2]));
            end
        end
        valid_in5 = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid5", valid_out5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_pool_2d_4_channel_size_2.md
MAX_POOL_2D_4_CHANNEL_SIZE_2 -- requirements
Module: max_pool_2d_4_channel_size_2

Interface
REQ-001 SHALL have parameter IMG_Width, default 4: input feature-map width in pixels (>=2).
REQ-002 SHALL have parameter IMG_Height, default 4: input feature-map height in pixels (>=2).
REQ-003 SHALL have parameter Datawidth, default 32: per-channel sample width, signed two's complement.
REQ-004 SHALL have port clk  input  1: clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port valid_in  input  1: In_0..In_3 carry one pixel this cycle.
REQ-007 SHALL have ports In_0, In_1, In_2, In_3  input  Datawidth each: channel samples from the 4-output-channel 1x1 conv stage.
REQ-008 SHALL have port valid_out  output  1: one-cycle pulse, Out_0..Out_3 hold a new pooled pixel.
REQ-009 SHALL have ports Out_0, Out_1, Out_2, Out_3  output  Datawidth each: registered pooled samples.
REQ-010 SHALL have port frame_done  output  1: one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-011 SHALL perform 2x2 max pooling, stride 2, independently per channel; the same window control drives all 4 channels.
REQ-012 SHALL accept pixels in raster order (row-major, col fastest); cycles with valid_in=0 SHALL change no state except valid_out/frame_done deasserting.
REQ-013 SHALL track col (0..IMG_Width-1) and row (0..IMG_Height-1), advancing col on each valid_in; at col=IMG_Width-1, col wraps to 0 and row increments; at the last pixel of the frame both wrap to 0.
REQ-014 SHALL use a per-channel line buffer of floor(IMG_Width/2) entries; no full-frame storage.
REQ-015 Even row, even col: SHALL capture In_k into a horizontal holding register h_k.
REQ-016 Even row, odd col: SHALL write max(h_k, In_k) to line buffer entry col/2.
REQ-017 Odd row, even col: SHALL load h_k = max(buf_k[col/2], In_k).
REQ-018 Odd row, odd col: SHALL register Out_k = max(h_k, In_k) and assert valid_out on the next cycle (latency 1 clk from bottom-right pixel of the window).
REQ-019 Comparisons SHALL be signed, full Datawidth; ties select either operand (equal values); no saturation or width change.
REQ-020 Odd IMG_Width: last column SHALL be consumed (counters advance) but produce no buffer write or output; odd IMG_Height: last row likewise ignored.
REQ-021 Outputs per frame SHALL equal floor(IMG_Width/2)*floor(IMG_Height/2).
REQ-022 frame_done SHALL pulse with the valid_out of window (floor(IMG_Height/2)-1, floor(IMG_Width/2)-1).
REQ-023 Out_0..Out_3 SHALL hold their last value while valid_out=0.
REQ-024 Back-to-back frames (valid_in continuous across frame boundary) SHALL be processed with no bubble or lost pixel.

Reset
REQ-025 On rst=1: valid_out=0, frame_done=0, Out_0..Out_3=0, col=0, row=0, h_k=0; line buffer need not be cleared (always written on an even row before read).
REQ-026 rst asserted mid-frame SHALL abort the frame; the next valid_in after rst deasserts is pixel (0,0) of a new frame.
REQ-027 rst SHALL take priority over valid_in in the same cycle.

Verification
REQ-028 4x4, continuous valid_in, In_k = r*4+c + 100*k -> Out_0 sequence 5,7,13,15; Out_3 305,307,313,315; 4 valid_out pulses; frame_done with the 4th.
REQ-029 4x4, Out_0 window values {-1,-5,-9,-3} in top-left window -> Out_0=-1 (signed compare).
REQ-030 5x5, In_0 = r*5+c -> Out_0 6,8,16,18; column 4 and row 4 produce no output; exactly 4 pulses.
REQ-031 4x4 test of REQ-028 with valid_in=0 inserted every other cycle -> identical output values, each valid_out 1 clk after its window's last pixel.
REQ-032 rst after 6 pixels of a frame, then full 4x4 frame -> outputs exactly as REQ-028; two consecutive frames back-to-back -> 8 correct pulses, 2 frame_done.
